sao_eo_stat_ctrl: RTL
=====================

# sao_eo_stat_ctrl

Controller that sequences the 16-sample SAO sum/diff datapath across the four edge-offset categories of a block. It accepts rows of 16 pre-classified samples (category code plus signed difference) through a valid/ready handshake. For each row it drives the datapath once per category and accumulates per-category sample counts and difference sums. After the programmed number of rows it presents final statistics to the SAO offset decision stage.

## Interface
- `NUM_CAT`, 4: EO categories accumulated, codes 1..4.
- `CNT_W`, 13: per-category count width; holds 256 rows × 16 = 4096.
- `SUM_W`, 18: per-category signed difference-sum width.
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start_i` in 1: one-cycle pulse; clears accumulators and latches `rows_i`. Ignored unless IDLE.
- `rows_i` in 9: rows in the block, 0..256.
- `in_valid_i` in 1: row data valid.
- `in_ready_o` out 1: row accepted when `in_valid_i && in_ready_o`.
- `cat_i` in 48: 16 × 3-bit category codes; sample j is bits [3j+2:3j].
- `diff_i` in 96: 16 × 6-bit two's-complement diffs; sample j is bits [6j+5:6j].
- `busy_o` out 1: high from the cycle after `start_i` until DONE exits.
- `done_o` out 1: one-cycle pulse, statistics final.
- `cnt_o` out NUM_CAT×CNT_W: category k+1 count is slice k.
- `sum_o` out NUM_CAT×SUM_W: category k+1 signed diff sum is slice k.

## Operation
- FSM states:
  - IDLE: on `start_i`, go to LOAD if `rows_i` ≠ 0, else to DONE.
  - LOAD: `in_ready_o`=1. On handshake, register `cat_i`/`diff_i`, set `cat_idx`=0, go to ACC.
  - ACC: one cycle per category, `cat_idx` 0..3.
    - At `cat_idx`=3 the row counter increments.
    - Go to DONE if this was the last row, else back to LOAD.
  - DONE: `done_o`=1 for one cycle, then IDLE.
- ACC cycle with `cat_idx`=k:
  - Datapath mask bit j = (registered code j == k+1).
  - Datapath diff inputs are the registered diffs.
  - `cnt[k] += num_sum`, with one exception: when all 16 mask bits are set, the 4-bit datapath count wraps to 0, so the controller adds 16 instead.
  - `sum[k] += sign-extend(diff_sum, 10→SUM_W)`.
- Codes 0, 5, 6 and 7 never match any category and contribute nothing.
- Widths never overflow within 256 rows. Extremes are +126976 and −131072; no saturation logic.
- `cnt_o`/`sum_o` are driven directly from the accumulators. They hold after DONE until the next accepted `start_i`, which zeroes them in the following cycle.
- `start_i` while busy: ignored, no effect on state or accumulators.
- `in_valid_i` outside LOAD: ignored; data must be held by the source until accepted.
- Reset asserted mid-operation: immediate abort, all state cleared, no `done_o`.

## Timing
- Reset values: state IDLE; `in_ready_o`, `busy_o` and `done_o` 0; all accumulators, the row counter and `cat_idx` 0.
- Handshake at cycle t: ACC occupies t+1..t+4; `in_ready_o` returns high at t+5. Throughput is 1 row per 5 cycles.
- Last row handshake at t: `done_o` high at cycle t+5, accumulators final from t+5 onward, `busy_o` low at t+6.
- `start_i` with `rows_i`=0 at t: `done_o` at t+1, all statistics 0.
- Datapath is combinational and must close timing in one cycle together with the accumulator add.

## Structure
- Shared package / defines file:
  - SAO EO category codes (`SAO_CAT_NONE`=0, `SAO_CAT_1..4`).
  - `SAO_EO_CAT_NUM`=4.
  - Default `CNT_W`/`SUM_W` widths.
  - FSM state encoding (2-bit: IDLE, LOAD, ACC, DONE).
- One sub-module instance: the existing `sao_sum_diff` datapath, shared across all four categories by time multiplexing. No other sub-modules.
- Row register, mask generation, accumulator bank and FSM stay in `sao_eo_stat_ctrl`.

## Test plan
- Single row, `rows_i`=1:
  - Stimulus: samples 0..3 are code 1 with diff +5; the rest code 0.
  - Required: `cnt_o` = {0,0,0,4}, category 1 sum = +20, `done_o` exactly 5 cycles after the handshake.
- Full-mask wrap:
  - Stimulus: all 16 samples code 2, diff −32.
  - Required: category 2 count = 16 (not 0), category 2 sum = −512.
- 256-row saturation-free extremes:
  - Stimulus, rows alternating: all code 3 diff +31, then all code 4 diff −32.
  - Required: category 3 count = 2048, sum = +63488; category 4 count = 2048, sum = −65536.
- Back-pressure:
  - Stimulus: `in_valid_i` high with changing data during ACC; `start_i` pulsed while busy.
  - Required: only LOAD-cycle data is accumulated; the start pulse has no effect.
- `rows_i`=0 and codes 5–7:
  - Required: `done_o` one cycle after `start_i` with zero statistics.
  - Required: a row of codes 5/6/7 leaves all accumulators unchanged.
- Reset mid-block:
  - Stimulus: assert `rst_n` low after 3 of 10 rows, then start a new 1-row block.
  - Required: outputs 0 during reset, no `done_o`, and the new block's results match a fresh run.

Source files
------------

// File: rtl/sao_eo_stat_ctrl_pkg.sv
// Shared definitions for the SAO edge-offset statistics controller:
// category codes, default widths and the controller state encoding.
package sao_eo_stat_ctrl_pkg;

    localparam logic [2:0] SAO_CAT_NONE = 3'd0;
    localparam logic [2:0] SAO_CAT_1    = 3'd1;
    localparam logic [2:0] SAO_CAT_2    = 3'd2;
    localparam logic [2:0] SAO_CAT_3    = 3'd3;
    localparam logic [2:0] SAO_CAT_4    = 3'd4;

    localparam int SAO_EO_CAT_NUM = 4;
    localparam int SAO_CNT_W      = 13;
    localparam int SAO_SUM_W      = 18;
    localparam int SAO_ROW_N      = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_ACC  = 2'd2,
        ST_DONE = 2'd3
    } sao_state_e;

    // Category code handled in the ACC cycle with index idx (idx 0 -> code 1).
    function automatic logic [2:0] sao_cat_code(input logic [1:0] idx);
        return {1'b0, idx} + SAO_CAT_1;
    endfunction

endpackage

// File: rtl/sao_sum_diff.sv
// Combinational 16-sample SAO datapath: counts masked samples (4-bit, wraps
// at 16) and sums their signed 6-bit differences into a 10-bit result.
module sao_sum_diff (
    input  logic        [15:0] mask_i,
    input  logic        [95:0] diff_i,
    output logic        [3:0]  num_sum_o,
    output logic signed [9:0]  diff_sum_o
);

    // Masked population count and sign-extended difference sum.
    always_comb begin
        num_sum_o  = 4'd0;
        diff_sum_o = 10'sd0;
        for (int j = 0; j < 16; j++) begin
            num_sum_o  = num_sum_o + {3'b000, mask_i[j]};
            diff_sum_o = diff_sum_o + (mask_i[j] ?
                         {{4{diff_i[6*j+5]}}, diff_i[6*j +: 6]} : 10'sd0);
        end
    end

endmodule

// File: rtl/sao_eo_stat_ctrl.sv
// Sequences one shared sao_sum_diff datapath over the four EO categories of
// each 16-sample row and accumulates per-category counts and difference sums.
module sao_eo_stat_ctrl
    import sao_eo_stat_ctrl_pkg::*;
#(
    parameter int NUM_CAT = SAO_EO_CAT_NUM,
    parameter int CNT_W   = SAO_CNT_W,
    parameter int SUM_W   = SAO_SUM_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start_i,
    input  logic [8:0]               rows_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [47:0]              cat_i,
    input  logic [95:0]              diff_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [NUM_CAT*CNT_W-1:0] cnt_o,
    output logic [NUM_CAT*SUM_W-1:0] sum_o
);

    sao_state_e                      state_q;
    logic [8:0]                      rows_q;
    logic [8:0]                      row_cnt_q;
    logic [1:0]                      cat_idx_q;
    logic [47:0]                     cat_q;
    logic [95:0]                     diff_q;
    logic                            in_ready_q;
    logic                            busy_q;
    logic                            done_q;
    logic [NUM_CAT-1:0][CNT_W-1:0]   cnt_q;
    logic [NUM_CAT-1:0][SUM_W-1:0]   sum_q;

    logic [15:0]                     mask_s;
    logic [3:0]                      num_sum_s;
    logic signed [9:0]               diff_sum_s;
    logic [4:0]                      cnt_add_s;

    // Mask of the registered samples that belong to the current category.
    always_comb begin
        mask_s = 16'd0;
        for (int j = 0; j < SAO_ROW_N; j++) begin
            mask_s[j] = (cat_q[3*j +: 3] == sao_cat_code(cat_idx_q));
        end
    end

    sao_sum_diff u_sum_diff (
        .mask_i     (mask_s),
        .diff_i     (diff_q),
        .num_sum_o  (num_sum_s),
        .diff_sum_o (diff_sum_s)
    );

    // A full mask wraps the 4-bit datapath count to zero; restore it to 16.
    assign cnt_add_s = (&mask_s) ? 5'd16 : {1'b0, num_sum_s};

    // Control FSM with registered handshake and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rows_q     <= 9'd0;
            row_cnt_q  <= 9'd0;
            cat_idx_q  <= 2'd0;
            cat_q      <= 48'd0;
            diff_q     <= 96'd0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        rows_q    <= rows_i;
                        row_cnt_q <= 9'd0;
                        busy_q    <= 1'b1;
                        if (rows_i != 9'd0) begin
                            state_q    <= ST_LOAD;
                            in_ready_q <= 1'b1;
                        end else begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (in_valid_i) begin
                        cat_q      <= cat_i;
                        diff_q     <= diff_i;
                        cat_idx_q  <= 2'd0;
                        in_ready_q <= 1'b0;
                        state_q    <= ST_ACC;
                    end
                end
                ST_ACC: begin
                    cat_idx_q <= cat_idx_q + 2'd1;
                    if (cat_idx_q == 2'd3) begin
                        row_cnt_q <= row_cnt_q + 9'd1;
                        if (row_cnt_q + 9'd1 == rows_q) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q    <= ST_LOAD;
                            in_ready_q <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q    <= ST_IDLE;
                    in_ready_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    // Accumulator bank: cleared by an accepted start, updated in ACC cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            sum_q <= '0;
        end else if (state_q == ST_IDLE && start_i) begin
            cnt_q <= '0;
            sum_q <= '0;
        end else if (state_q == ST_ACC) begin
            cnt_q[cat_idx_q] <= cnt_q[cat_idx_q] + CNT_W'(cnt_add_s);
            sum_q[cat_idx_q] <= sum_q[cat_idx_q] + SUM_W'(diff_sum_s);
        end
    end

    assign in_ready_o = in_ready_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign cnt_o      = cnt_q;
    assign sum_o      = sum_q;

endmodule
